// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection and a
// saturating count of load-use bubbles.
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              id_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic w_load_use;
    logic w_cnt_sat;

    // A load in EX whose destination is read by the instruction in ID cannot forward yet.
    assign w_load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                        ((id_uses_rs1 & (ex_rd == id_rs1)) |
                         (id_uses_rs2 & (ex_rd == id_rs2)));

    assign id_stall  = ~flush & (ex_stall | w_load_use);
    assign w_cnt_sat = &bubble_cnt;

    // Reset, flush and load-use all leave an all-zero bubble; a stall holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!ex_stall && w_load_use)) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_ctrl      <= '0;
        end else if (!ex_stall) begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1_data  <= id_rs1_data;
            ex_rs2_data  <= id_rs2_data;
            ex_imm       <= id_imm;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_mem_read  <= id_valid & id_mem_read;
            ex_reg_write <= id_valid & id_reg_write;
            ex_ctrl      <= id_valid ? id_ctrl : '0;
        end
    end

    // Only genuine load-use bubbles are counted; flushes are not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!flush && !ex_stall && w_load_use && !w_cnt_sat) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Table-driven self-checking bench for id_ex_stage_reg; a second instance with a
// 2-bit counter exercises bubble counter saturation.
module tb_id_ex_stage_reg;

    typedef enum logic [1:0] {K_LOAD, K_HOLD, K_ZERO} kind_e;

    typedef struct {
        logic        rstN, flsh, exStall, valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        mr, rw;
        logic [11:0] ctrl;
        kind_e       kind;
        logic        expStall;
        logic [15:0] expCnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_uses_rs1, id_uses_rs2, id_mem_read, id_reg_write;
    logic        ex_stall, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [11:0] id_ctrl;

    logic        ex_valid, ex_mem_read, ex_reg_write, id_stall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;
    logic [15:0] bubble_cnt;

    logic        s2Valid, s2Mr, s2Rw, s2Stall;
    logic [31:0] s2Pc, s2Rs1d, s2Rs2d, s2Imm;
    logic [4:0]  s2Rs1, s2Rs2, s2Rd;
    logic [11:0] s2Ctrl;
    logic [1:0]  s2Cnt;

    int          assertCount = 0;
    int          failCount   = 0;

    logic        eValid, eMr, eRw;
    logic [31:0] ePc, eRs1d, eRs2d, eImm;
    logic [4:0]  eRs1, eRs2, eRd;
    logic [11:0] eCtrl;

    vec_t        vecs[$];

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_ctrl(id_ctrl), .ex_stall(ex_stall),
        .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_ctrl(ex_ctrl), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage_reg #(.XLEN(32), .CTRL_W(12), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_ctrl(id_ctrl), .ex_stall(ex_stall),
        .flush(flush), .ex_valid(s2Valid), .ex_pc(s2Pc), .ex_rs1_data(s2Rs1d),
        .ex_rs2_data(s2Rs2d), .ex_imm(s2Imm), .ex_rs1(s2Rs1), .ex_rs2(s2Rs2),
        .ex_rd(s2Rd), .ex_mem_read(s2Mr), .ex_reg_write(s2Rw),
        .ex_ctrl(s2Ctrl), .id_stall(s2Stall), .bubble_cnt(s2Cnt)
    );

    function automatic vec_t mkRow(
        input logic rstN, input logic flsh, input logic exStall, input logic valid,
        input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
        input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
        input logic rw, input logic [11:0] ctrl, input kind_e kind,
        input logic expStall, input logic [15:0] expCnt);
        vec_t v;
        v.rstN = rstN; v.flsh = flsh; v.exStall = exStall; v.valid = valid;
        v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.rw = rw; v.ctrl = ctrl; v.kind = kind;
        v.expStall = expStall; v.expCnt = expCnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input logic [15:0] cnt);
        checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, eValid});
        checkOutput("ex_pc", ex_pc, ePc);
        checkOutput("ex_rs1_data", ex_rs1_data, eRs1d);
        checkOutput("ex_rs2_data", ex_rs2_data, eRs2d);
        checkOutput("ex_imm", ex_imm, eImm);
        checkOutput("ex_rs1", {27'd0, ex_rs1}, {27'd0, eRs1});
        checkOutput("ex_rs2", {27'd0, ex_rs2}, {27'd0, eRs2});
        checkOutput("ex_rd", {27'd0, ex_rd}, {27'd0, eRd});
        checkOutput("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, eMr});
        checkOutput("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, eRw});
        checkOutput("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, eCtrl});
        checkOutput("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, cnt});
        checkOutput("bubble_cnt_sat", {30'd0, s2Cnt}, (cnt > 16'd3) ? 32'd3 : {16'd0, cnt});
    endtask

    task automatic setExpZero();
        eValid = 0; eMr = 0; eRw = 0; ePc = 0; eRs1d = 0; eRs2d = 0; eImm = 0;
        eRs1 = 0; eRs2 = 0; eRd = 0; eCtrl = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n = v.rstN; flush = v.flsh; ex_stall = v.exStall; id_valid = v.valid;
        id_pc = v.pc; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        id_rd = v.rd; id_mem_read = v.mr; id_reg_write = v.rw; id_ctrl = v.ctrl;
        #1;
        checkOutput("id_stall", {31'd0, id_stall}, {31'd0, v.expStall});
        if (v.kind == K_ZERO) begin
            setExpZero();
        end else if (v.kind == K_LOAD) begin
            eValid = v.valid; ePc = v.pc; eRs1d = v.rs1d; eRs2d = v.rs2d; eImm = v.imm;
            eRs1 = v.rs1; eRs2 = v.rs2; eRd = v.rd;
            eMr = v.valid & v.mr; eRw = v.valid & v.rw;
            eCtrl = v.valid ? v.ctrl : 12'd0;
        end
        @(posedge clk);
        #1;
        checkAll(v.expCnt);
    endtask

    initial begin
        // Reset with random inputs held for two clocks.
        rst_n = 0;
        flush = 1'($urandom); ex_stall = 1'($urandom); id_valid = 1'($urandom);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
        id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
        id_mem_read = 1'($urandom); id_reg_write = 1'($urandom); id_ctrl = 12'($urandom);
        repeat (2) @(posedge clk);
        #1;
        setExpZero();
        checkAll(16'd0);
        @(negedge clk);
        flush = 0; ex_stall = 0; id_valid = 0;
        #1;
        checkOutput("id_stall_idle", {31'd0, id_stall}, 32'd0);

        vecs.push_back(mkRow(1,0,0,1,32'h100,32'hDEADBEEF,32'h12345678,32'hFFFFFFF0,1,2,1,1,3,0,1,12'hABC,K_LOAD,0,0));
        vecs.push_back(mkRow(1,0,0,1,32'h104,32'h1000,0,4,2,0,1,0,5,1,1,12'h011,K_LOAD,0,0));
        vecs.push_back(mkRow(1,0,0,1,32'h108,32'h11,32'h22,0,5,7,1,1,6,0,1,12'h022,K_ZERO,1,1));
        vecs.push_back(mkRow(1,0,0,1,32'h108,32'h11,32'h22,0,5,7,1,1,6,0,1,12'h022,K_LOAD,0,1));
        vecs.push_back(mkRow(1,0,0,1,32'h10C,32'h2000,0,8,1,0,1,0,0,1,1,12'h011,K_LOAD,0,1));
        vecs.push_back(mkRow(1,0,0,1,32'h110,0,0,0,0,0,1,1,8,0,1,12'h033,K_LOAD,0,1));
        vecs.push_back(mkRow(1,0,0,1,32'h114,32'h3000,0,32'hC,1,0,1,0,9,1,1,12'h011,K_LOAD,0,1));
        vecs.push_back(mkRow(1,0,0,1,32'h118,32'h44,32'h99,32'h7FF,4,9,1,0,10,0,1,12'h044,K_LOAD,0,1));
        vecs.push_back(mkRow(1,0,1,1,32'h200,32'hA,32'hB,32'hC,9,9,1,1,12,1,1,12'h0F0,K_HOLD,1,1));
        vecs.push_back(mkRow(1,0,1,1,32'h204,32'h1A,32'h1B,32'h1C,2,3,1,1,13,0,1,12'h0F1,K_HOLD,1,1));
        vecs.push_back(mkRow(1,0,1,0,32'h208,32'h2A,32'h2B,32'h2C,4,5,0,1,14,1,0,12'h0F2,K_HOLD,1,1));
        vecs.push_back(mkRow(1,0,0,0,32'h300,32'h5555,32'h6666,32'h77,3,4,1,1,11,1,1,12'hFFF,K_LOAD,0,1));
        vecs.push_back(mkRow(1,0,0,1,32'h120,32'h4000,0,32'h10,1,0,1,0,5,1,1,12'h011,K_LOAD,0,1));
        vecs.push_back(mkRow(1,1,1,1,32'h124,32'h11,32'h22,0,5,7,1,1,6,0,1,12'h022,K_ZERO,0,1));
        vecs.push_back(mkRow(1,0,0,1,32'h128,32'h4000,0,32'h10,1,0,1,0,5,1,1,12'h011,K_LOAD,0,1));
        vecs.push_back(mkRow(1,0,1,1,32'h12C,32'h11,32'h22,0,5,7,1,1,6,0,1,12'h022,K_HOLD,1,1));
        vecs.push_back(mkRow(1,0,0,1,32'h12C,32'h11,32'h22,0,5,7,1,1,6,0,1,12'h022,K_ZERO,1,2));
        vecs.push_back(mkRow(1,0,0,1,32'h130,32'h4000,0,32'h10,1,0,1,0,5,1,1,12'h011,K_LOAD,0,2));
        vecs.push_back(mkRow(0,0,1,1,32'h134,32'h11,32'h22,0,5,7,1,1,6,0,1,12'h022,K_ZERO,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Repeated load-use pairs: 16-bit counter keeps counting, 2-bit one sticks at 3.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(mkRow(1,0,0,1,32'h400,32'h8000,0,0,1,0,1,0,5,1,1,12'h011,K_LOAD,0,16'(i-1)));
            applyStimulus(mkRow(1,0,0,1,32'h404,32'h1,32'h2,0,7,5,0,1,6,0,1,12'h022,K_ZERO,1,16'(i)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
